// File: rtl/vec_result_writeback.sv
// Serializes a captured LANES-word vector into one data-memory write per cycle, on bank 2 and/or bank 3.
// First write lands the cycle after accept. ready stays low until the DONE cycle has passed.
module vec_result_writeback #(
   parameter int LANES  = 8,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_mem_2,
   input  logic                     w_mem_3,
   input  logic [ADDR_W-1:0]        addr_base,
   input  logic [LANES*WIDTH-1:0]   lanes_in,
   output logic                     ready,
   output logic                     mem_we,
   output logic [1:0]               mem_bank,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [WIDTH-1:0]         mem_data,
   output logic                     done
);

   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

   typedef enum logic [1:0] {IDLE, WR2, WR3, DONE} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic [IDX_W-1:0]         nxt_idx;
   logic [LANES*WIDTH-1:0]   cap_vec;
   logic [ADDR_W-1:0]        cap_base;
   logic                     pend3;

   assign nxt_idx = idx + IDX_W'(1);

   // idx always names the lane currently presented on the mem_* registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         cap_vec  <= '0;
         cap_base <= '0;
         pend3    <= 1'b0;
         ready    <= 1'b1;
         mem_we   <= 1'b0;
         mem_bank <= 2'd0;
         mem_addr <= '0;
         mem_data <= '0;
         done     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (w_mem_2 | w_mem_3) begin
                  cap_vec  <= lanes_in;
                  cap_base <= addr_base;
                  idx      <= '0;
                  pend3    <= w_mem_2 & w_mem_3;
                  state    <= w_mem_2 ? WR2 : WR3;
                  ready    <= 1'b0;
                  mem_we   <= 1'b1;
                  mem_bank <= w_mem_2 ? 2'd2 : 2'd3;
                  mem_addr <= addr_base;
                  mem_data <= lanes_in[WIDTH-1:0];
               end
            end
            WR2, WR3: begin
               if (idx == LAST) begin
                  if (state == WR2 && pend3) begin
                     // Mirrored store: replay the same vector and addresses on bank 3.
                     state    <= WR3;
                     idx      <= '0;
                     pend3    <= 1'b0;
                     mem_bank <= 2'd3;
                     mem_addr <= cap_base;
                     mem_data <= cap_vec[WIDTH-1:0];
                  end else begin
                     state  <= DONE;
                     mem_we <= 1'b0;
                     done   <= 1'b1;
                  end
               end else begin
                  idx      <= nxt_idx;
                  mem_addr <= cap_base + ADDR_W'(nxt_idx);
                  mem_data <= cap_vec[nxt_idx*WIDTH +: WIDTH];
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_result_writeback.sv
// Bench for vec_result_writeback: directed table, multi-cycle corner sequences and random requests vs a write-list model.
module tb_vec_result_writeback;
   localparam int LANES  = 8;
   localparam int WIDTH  = 32;
   localparam int ADDR_W = 8;

   typedef logic [LANES*WIDTH-1:0] vec_t;
   typedef struct {
      logic [1:0]  bank;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;
   typedef struct {
      logic        w2;
      logic        w3;
      logic [7:0]  base;
      int          exp_n;
      int          exp_b2;
      logic [7:0]  exp_last_addr;
      logic [1:0]  exp_last_bank;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        w_mem_2 = 1'b0;
   logic        w_mem_3 = 1'b0;
   logic [7:0]  addr_base = '0;
   vec_t        lanes_in = '0;
   logic        ready, mem_we, done;
   logic [1:0]  mem_bank;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data;

   vec_result_writeback #(.LANES(LANES), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .w_mem_2(w_mem_2), .w_mem_3(w_mem_3),
      .addr_base(addr_base), .lanes_in(lanes_in), .ready(ready),
      .mem_we(mem_we), .mem_bank(mem_bank), .mem_addr(mem_addr),
      .mem_data(mem_data), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   wr_t wq[$];
   int  dq[$];
   always @(negedge clk) begin
      wr_t w;
      if (mem_we) begin
         w.bank = mem_bank; w.addr = mem_addr; w.data = mem_data; w.cyc = cyc;
         wq.push_back(w);
      end
      if (done) dq.push_back(cyc);
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom;
      return v;
   endfunction

   task automatic wait_ready();
      for (int k = 0; k < 100 && !ready; k++) step();
      chk("ready_wait", ready, 1);
   endtask

   task automatic wait_done(input int n);
      for (int k = 0; k < 200 && dq.size() < n; k++) step();
      chk("done_wait", dq.size() >= n, 1);
   endtask

   // Reference: each requested bank gets LANES writes (bank 2 first), address base+i wrapping, data lane i, back to back.
   task automatic compare(input logic ew2, input logic ew3, input logic [7:0] b, input vec_t v, input int t0);
      wr_t exp[$];
      wr_t e;
      logic [7:0] a;
      for (int bk = 2; bk <= 3; bk++) begin
         if ((bk == 2 && ew2) || (bk == 3 && ew3)) begin
            for (int i = 0; i < LANES; i++) begin
               a = b + 8'(i);
               e.bank = 2'(bk); e.addr = a; e.data = v[i*WIDTH +: WIDTH];
               e.cyc = t0 + 1 + exp.size();
               exp.push_back(e);
            end
         end
      end
      chk("n_writes", wq.size(), exp.size());
      for (int i = 0; i < exp.size() && i < wq.size(); i++)
         chk($sformatf("write%0d{bank,addr,data,cyc}", i),
             {wq[i].bank, wq[i].addr, wq[i].data, wq[i].cyc[21:0]},
             {exp[i].bank, exp[i].addr, exp[i].data, exp[i].cyc[21:0]});
      chk("done_count", dq.size(), 1);
      if (dq.size() > 0) chk("done_cycle", dq[0], t0 + 1 + exp.size());
   endtask

   task automatic run_req(input logic r2, input logic r3, input logic [7:0] b, input vec_t v);
      int t0;
      wq.delete(); dq.delete();
      wait_ready();
      w_mem_2 = r2; w_mem_3 = r3; addr_base = b; lanes_in = v;
      t0 = cyc;
      step();
      w_mem_2 = 1'b0; w_mem_3 = 1'b0;
      chk("busy_after_accept", ready, 0);
      wait_done(1);
      step();
      chk("ready_after_done", ready, 1);
      compare(r2, r3, b, v, t0);
   endtask

   initial begin
      rec_t tbl[4];
      vec_t va, vb;
      int   n0, nb2;
      logic [1:0] r;

      // Reset state
      repeat (3) step();
      chk("rst_ready", ready, 1);
      chk("rst_outs", {mem_we, mem_bank, mem_addr, mem_data, done}, '0);
      rst = 1'b0;
      step();

      tbl[0] = '{1'b1, 1'b0, 8'h10, 8,  8,  8'h17, 2'd2};
      tbl[1] = '{1'b1, 1'b1, 8'h20, 16, 8,  8'h27, 2'd3};
      tbl[2] = '{1'b0, 1'b1, 8'hFC, 8,  0,  8'h03, 2'd3};
      tbl[3] = '{1'b1, 1'b1, 8'hFE, 16, 8,  8'h05, 2'd3};
      for (int t = 0; t < 4; t++) begin
         if (t == 0) for (int i = 0; i < LANES; i++) va[i*WIDTH +: WIDTH] = 32'h100 + i;
         else va = rand_vec();
         run_req(tbl[t].w2, tbl[t].w3, tbl[t].base, va);
         chk($sformatf("tbl%0d_n", t), wq.size(), tbl[t].exp_n);
         nb2 = 0;
         foreach (wq[i]) if (wq[i].bank == 2'd2) nb2++;
         chk($sformatf("tbl%0d_bank2_cnt", t), nb2, tbl[t].exp_b2);
         if (wq.size() > 0) begin
            chk($sformatf("tbl%0d_last_addr", t), wq[wq.size()-1].addr, tbl[t].exp_last_addr);
            chk($sformatf("tbl%0d_last_bank", t), wq[wq.size()-1].bank, tbl[t].exp_last_bank);
         end
      end

      // Reset while the lane-3 write is on the bus
      wq.delete(); dq.delete();
      wait_ready();
      w_mem_2 = 1'b1; addr_base = 8'h10; lanes_in = rand_vec();
      step();
      w_mem_2 = 1'b0;
      for (int k = 0; k < 50 && wq.size() < 4; k++) step();
      chk("rst_mid_reached_idx3", wq.size(), 4);
      rst = 1'b1;
      step();
      chk("rst_mid_ready", ready, 1);
      chk("rst_mid_outs", {mem_we, mem_bank, mem_addr, mem_data, done}, '0);
      rst = 1'b0;
      n0 = wq.size();
      repeat (12) step();
      chk("rst_mid_no_writes", wq.size(), n0);
      chk("rst_mid_no_done", dq.size(), 0);

      // Input changes and a stray request while busy are ignored
      wq.delete(); dq.delete();
      wait_ready();
      va = rand_vec(); vb = rand_vec();
      w_mem_2 = 1'b1; addr_base = 8'h40; lanes_in = va;
      n0 = cyc;
      step();
      w_mem_2 = 1'b0;
      step(); step();
      lanes_in = vb; addr_base = 8'h80; w_mem_2 = 1'b1;
      step();
      w_mem_2 = 1'b0;
      wait_done(1);
      repeat (4) step();
      compare(1'b1, 1'b0, 8'h40, va, n0);
      chk("busy_req_ready_back", ready, 1);

      // Back-to-back with w_mem_2 held high
      wq.delete(); dq.delete();
      wait_ready();
      va = rand_vec(); vb = rand_vec();
      w_mem_2 = 1'b1; addr_base = 8'h30; lanes_in = va;
      step();
      lanes_in = vb;
      for (int k = 0; k < 100 && wq.size() < LANES + 1; k++) step();
      w_mem_2 = 1'b0;
      wait_done(2);
      step();
      chk("b2b_n", wq.size(), 2 * LANES);
      if (wq.size() == 2 * LANES) begin
         chk("b2b_gap", wq[LANES].cyc - wq[LANES-1].cyc, 3);
         for (int i = 0; i < LANES; i++) begin
            chk($sformatf("b2b_A%0d", i), wq[i].data, va[i*WIDTH +: WIDTH]);
            chk($sformatf("b2b_B%0d", i), wq[LANES+i].data, vb[i*WIDTH +: WIDTH]);
         end
      end

      // Random requests against the model
      for (int n = 0; n < 20; n++) begin
         r = 2'($urandom_range(1, 3));
         run_req(r[0], r[1], 8'($urandom), rand_vec());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/vec_result_writeback.md
Name: vec_result_writeback

Overview:
- Memory-side responder for the vector CPU's store requests.
- Accepts a write request on bank 2 (w_mem_2) and/or bank 3 (w_mem_3), together with a packed vector of LANES result words (mul/sum/add results) and a base word address.
- Serializes the vector into one memory write per cycle on a single-port data-memory interface.
- Holds the CPU off with ready=0 until the whole vector has been written.

Parameters:
- LANES, 8, number of 32-bit result words per request (legal range 1..16).
- WIDTH, 32, bits per lane word.
- ADDR_W, 8, word-address width of the data memory.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- w_mem_2  in  1  write request, bank 2.
- w_mem_3  in  1  write request, bank 3.
- addr_base  in  ADDR_W  word address of lane 0.
- lanes_in  in  LANES*WIDTH  packed result vector; lane i is bits [i*WIDTH +: WIDTH].
- ready  out  1  block can accept a request this cycle.
- mem_we  out  1  memory write strobe.
- mem_bank  out  2  bank select: 2'd2 or 2'd3.
- mem_addr  out  ADDR_W  write word address.
- mem_data  out  WIDTH  write data.
- done  out  1  one-cycle pulse after the last write of a request.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - ready=1, mem_we=0, mem_bank=0, mem_addr=0, mem_data=0, done=0.
  - Internal lane counter, captured vector, captured base and pending-bank-3 flag all cleared.
  - Reset mid-operation abandons the request with no further mem_we.
- Accept rule:
  - A request is accepted on an edge where ready=1 and (w_mem_2 | w_mem_3).
  - On accept, lanes_in and addr_base are registered; later changes on those inputs have no effect on the request.
  - Requests seen while ready=0 are ignored; the CPU must hold its request until ready=1.
- States:
  - IDLE: ready=1, mem_we=0.
    - Accept with w_mem_2 → WR2, idx=0, pend3=w_mem_3.
    - Accept with w_mem_3 only → WR3, idx=0.
  - WR2: ready=0, mem_we=1, mem_bank=2.
    - mem_addr=(base+idx) mod 2^ADDR_W, mem_data=lane[idx].
    - idx increments each cycle.
    - At idx=LANES-1: if pend3, go to WR3 with idx=0; otherwise go to DONE.
  - WR3: same as WR2 with mem_bank=3. At idx=LANES-1 go to DONE.
  - DONE: ready=0, mem_we=0, done=1 for exactly one cycle, then IDLE.
- All mem_* outputs are registered.
- Latency and throughput:
  - First write is visible on the cycle after accept.
  - Single bank: LANES write cycles plus 1 DONE cycle, so the next accept is possible LANES+2 cycles after the previous one.
  - w_mem_2 and w_mem_3 together: bank 2 is fully written first, then bank 3 with the same data and addresses (mirrored store), giving 2*LANES write cycles plus DONE.
- Address arithmetic is modulo 2^ADDR_W. Example: base=8'hFE, LANES=4 gives addresses FE, FF, 00, 01.
- When mem_we=0, mem_addr, mem_data and mem_bank hold their last values.
- LANES=1 is legal: WR2 lasts 1 cycle.

Test Plan:
1. Reset during WR2 at idx=3 (LANES=8) → next cycle mem_we=0, ready=1, done=0, all outputs 0; no further writes occur.
2. w_mem_2=1, addr_base=8'h10, lane i=32'h100+i → mem_we=1 for 8 consecutive cycles starting 1 cycle after accept.
   - mem_bank=2, addresses 10..17, data 100..107.
   - done pulses once on the cycle after the write to 8'h17.
   - ready returns to 1 the following cycle.
3. w_mem_2=w_mem_3=1, base=8'h20 → 8 writes on bank 2 (addresses 20..27), then 8 writes on bank 3 (addresses 20..27, same data), then one done pulse; 17 cycles from the first write to done.
4. w_mem_3 only, base=8'hFC → bank 3 writes to addresses FC, FD, FE, FF, 00, 01, 02, 03 (wrap-around); mem_bank is never 2.
5. Start a request, then change lanes_in/addr_base and pulse w_mem_2 while ready=0 → written data matches the originally captured vector; no second request starts; the next request is accepted only after ready=1.
6. Two back-to-back requests with w_mem_2 held high, with data sets A and B → write bursts are separated by exactly one cycle of mem_we=0 (the DONE cycle) plus the accept cycle; the second burst carries data B.
